message: RTL and testbench
==========================

Name: message

Overview:
- Scrolling text driver for a 6-digit seven-segment bank.
- Holds a fixed 16-character ASCII message: `''␣HELLO␣CLIP.''` (indices 0..15).
- Periodically advances a wrap-around window start pointer.
- Decodes the 6 visible characters to active-low segment patterns.
- Sits between the board clock/reset and the HEX display pins.

Parameters:
- STEP_CYCLES, 25_000_000: clock cycles per one-character scroll step (0.5 s at 50 MHz). Legal range ≥2.
- NUM_DIGITS, 6: number of display digits. Fixed at 6 for this revision; other values are not supported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  scroll enable; when 0 the step counter and pointer hold
- hex  out  48  six 8-bit segment bytes, hex[8k+7:8k] = digit k; digit 5 is leftmost
- ptr  out  4  current window start index (message index shown on digit 5)

Behaviour:
- Message ROM, combinational, 16x8 ASCII:
  - idx 0,1,14,15 = 0x27 (apostrophe)
  - idx 2,8 = 0x20 (space)
  - idx 3..7 = H E L L O
  - idx 9..12 = C L I P
  - idx 13 = 0x2E (period)
- Step counter cnt, width clog2(STEP_CYCLES):
  - When en=1: if cnt==STEP_CYCLES-1 then cnt<=0 and ptr<=ptr+1 (4-bit natural wrap, 15→0); else cnt<=cnt+1.
  - When en=0: cnt and ptr hold.
- Window: digit k (k=5..0) shows message[(ptr + (5-k)) mod 16], using 4-bit modular addition.
- Segment byte encoding:
  - Active-low: 0 = lit.
  - Bit order: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.
- Glyphs:
  - space=0xFF
  - '=0xFD
  - H=0x89
  - E=0x86
  - L=0xC7
  - O=0xC0
  - C=0xC6
  - I=0xF9
  - P=0x8C
  - .=0x7F
  - any other code=0xBF (dash)
- hex is registered: it reflects the ptr value of the previous cycle, so latency is 1 cycle after a ptr change.
- Reset, synchronous, takes priority over en:
  - cnt=0, ptr=0, hex=48'hFFFF_FFFF_FFFF (all blank).
  - First cycle after reset deassertion: hex shows the ptr=0 window.
- Reset asserted mid-step discards the partial count; there is no carry-over.
- ptr output is combinational from the ptr register; it has no extra latency.

Optional Feature:
- Macro MESSAGE_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit, after en).
  - Scrolling advances only when en=1 and pause=0.
  - While pause=1, cnt holds and hex keeps updating from the unchanged ptr.
- When undefined: no pause port; behaviour exactly as above.

Decomposition:
- Package message_pkg holds:
  - MSG_LEN=16
  - the message contents as a localparam array
  - segment glyph constants (SEG_BLANK, SEG_APOS, SEG_H, …, SEG_DASH)
  - typedef seg_t = logic [7:0]
- One natural sub-module, char_to_seg: a combinational ASCII→seg_t decoder, instantiated 6 times.
- The ROM is a case/array inside message; there is no separate ROM module.

Test Plan (STEP_CYCLES=4):
- Reset held 3 cycles:
  - During reset: hex=FFFF_FFFF_FFFF, ptr=0.
  - 1 cycle after release: hex[47:0]=FD_FD_FF_89_86_C7, digit5→digit0.
- en=1, run 4 cycles after reset → ptr=1. Next cycle hex=FD_FF_89_86_C7_C7.
- Run to ptr=3 → hex=89_86_C7_C7_C0_FF (HELLO␣).
- Run to ptr=15, then one more step:
  - At ptr=15: hex=FD_FD_FD_FF_89_86.
  - Next step: ptr wraps to 0.
- en=0 for 10 cycles mid-step → ptr and hex unchanged. Resume: remaining steps complete with no lost count.
- Assert reset at cnt=2, ptr=7 → next cycle ptr=0, hex blank. Then the step resumes from cnt=0.
- With MESSAGE_PAUSE_EN, pause=1 for 8 cycles → ptr frozen; pause=0 → scrolling continues.

Source files
------------

// File: rtl/message_pkg.sv
// message_pkg
//   Shared definitions for the scrolling seven-segment message driver.
//   - seg_t      : one active-low segment byte (bit0=a .. bit6=g, bit7=dp)
//   - MSG_LEN    : number of characters in the message (wraps modulo 16)
//   - MSG_ROM    : the fixed ASCII message, index 0 is the first character
//   - SEG_*      : glyph patterns used by char_to_seg
package message_pkg;

    typedef logic [7:0] seg_t;

    localparam int MSG_LEN = 16;

    // '' HELLO CLIP.''
    localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
        8'h27, 8'h27, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
        8'h20, 8'h43, 8'h4C, 8'h49, 8'h50, 8'h2E, 8'h27, 8'h27
    };

    // Active-low: a 0 bit lights the segment.
    localparam seg_t SEG_BLANK = 8'hFF;
    localparam seg_t SEG_APOS  = 8'hFD;
    localparam seg_t SEG_H     = 8'h89;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_L     = 8'hC7;
    localparam seg_t SEG_O     = 8'hC0;
    localparam seg_t SEG_C     = 8'hC6;
    localparam seg_t SEG_I     = 8'hF9;
    localparam seg_t SEG_P     = 8'h8C;
    localparam seg_t SEG_DOT   = 8'h7F;
    localparam seg_t SEG_DASH  = 8'hBF;

endpackage

// File: rtl/message_char_to_seg.sv
// char_to_seg
//   Combinational ASCII -> active-low seven-segment decoder.
//   Characters without a dedicated glyph are shown as a dash.
//   Ports:
//     ch  : ASCII code
//     seg : segment byte (bit0=a .. bit6=g, bit7=dp), 0 = lit
module char_to_seg
    import message_pkg::*;
(
    input  logic [7:0] ch,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (ch)
            8'h20: seg = SEG_BLANK;
            8'h27: seg = SEG_APOS;
            8'h48: seg = SEG_H;
            8'h45: seg = SEG_E;
            8'h4C: seg = SEG_L;
            8'h4F: seg = SEG_O;
            8'h43: seg = SEG_C;
            8'h49: seg = SEG_I;
            8'h50: seg = SEG_P;
            8'h2E: seg = SEG_DOT;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/message.sv
// message
//   Scrolling text driver for a 6-digit seven-segment bank. A step counter
//   advances a wrap-around window start pointer every STEP_CYCLES enabled
//   cycles; the six visible characters are decoded and registered onto hex.
//   Optional feature: define MESSAGE_PAUSE_EN to add a pause input that
//   freezes scrolling while display refresh continues.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high; clears counter/pointer, blanks hex
//     en    : scroll enable; counter and pointer hold when low
//     pause : (MESSAGE_PAUSE_EN only) holds counter and pointer when high
//     hex   : six segment bytes, hex[8k+7:8k] = digit k, digit 5 leftmost
//     ptr   : current window start index (shown on digit 5), no latency
module message
    import message_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int NUM_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
`ifdef MESSAGE_PAUSE_EN
    input  logic                    pause,
`endif
    output logic [8*NUM_DIGITS-1:0] hex,
    output logic [3:0]              ptr
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0]           cnt;
    logic [3:0]              ptr_q;
    logic                    advance;
    logic [8*NUM_DIGITS-1:0] window;

`ifdef MESSAGE_PAUSE_EN
    assign advance = en & ~pause;
`else
    assign advance = en;
`endif

    // Step counter and window pointer; pointer wraps naturally at 4 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            ptr_q <= '0;
        end else if (advance) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                ptr_q <= ptr_q + 4'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Digit k shows message[ptr + (NUM_DIGITS-1-k)] so the leftmost digit
    // carries the window start.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [3:0] idx;
        logic [7:0] ch;
        assign idx = ptr_q + 4'(NUM_DIGITS - 1 - k);
        assign ch  = MSG_ROM[idx];
        char_to_seg u_dec (
            .ch  (ch),
            .seg (window[8*k +: 8])
        );
    end

    // Registered display: one cycle behind the pointer, blank during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            hex <= window;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: tb/tb_message.sv
module tb_message;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        pause = 1'b0;
  logic [47:0] hex;
  logic [3:0]  ptr;

  int checks = 0;
  int fails  = 0;

  // expected {ptr, hex} after each driven cycle
  logic [51:0] exp_q[$];

  // bench model state
  int          m_cnt = 0;
  logic [3:0]  m_ptr = '0;
  logic [47:0] m_hex = '1;

  logic [127:0] msg_bits = "'' HELLO CLIP.''";

  message #(.STEP_CYCLES(STEP), .NUM_DIGITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
`ifdef MESSAGE_PAUSE_EN
    .pause (pause),
`endif
    .hex   (hex),
    .ptr   (ptr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] glyph(input logic [7:0] c);
    case (c)
      " ":     return 8'hFF;
      "'":     return 8'hFD;
      "H":     return 8'h89;
      "E":     return 8'h86;
      "L":     return 8'hC7;
      "O":     return 8'hC0;
      "C":     return 8'hC6;
      "I":     return 8'hF9;
      "P":     return 8'h8C;
      ".":     return 8'h7F;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [47:0] window_of(input logic [3:0] p);
    logic [47:0] w;
    logic [3:0]  i;
    w = '0;
    for (int d = 0; d < 6; d++) begin
      i = p + 4'(d);
      w[8*(5-d) +: 8] = glyph(msg_bits[8*(15-int'(i)) +: 8]);
    end
    return w;
  endfunction

  // driver: one clock cycle of stimulus; updates the model and queues the
  // expected post-edge outputs; returns 1 time unit after the rising edge
  task automatic drive_cycle(input logic r, input logic e, input logic p);
    logic adv;
    @(negedge clk);
    reset = r;
    en    = e;
    pause = p;
`ifdef MESSAGE_PAUSE_EN
    adv = e & ~p;
`else
    adv = e;
`endif
    if (r) begin
      m_cnt = 0;
      m_ptr = '0;
      m_hex = '1;
    end else begin
      m_hex = window_of(m_ptr);
      if (adv) begin
        if (m_cnt == STEP - 1) begin
          m_cnt = 0;
          m_ptr = m_ptr + 4'd1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    exp_q.push_back({m_ptr, m_hex});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [51:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({ptr, hex} !== e) begin
        fails++;
        $display("FAIL scoreboard: got ptr=%0d hex=%h, expected ptr=%0d hex=%h",
                 ptr, hex, e[51:48], e[47:0]);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (hex !== 48'hFFFF_FFFF_FFFF || ptr !== 4'd0) begin
        fails++;
        $display("FAIL reset_hold: got ptr=%0d hex=%h, expected ptr=0 hex=ffffffffffff", ptr, hex);
      end
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex !== 48'hFDFD_FF89_86C7 || ptr !== 4'd0) begin
      fails++;
      $display("FAIL reset_release: got ptr=%0d hex=%h, expected ptr=0 hex=fdfdff8986c7", ptr, hex);
    end
  endtask

  task automatic test_scroll();
    int n;
    // three more enabled cycles complete the first step
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (ptr !== 4'd1) begin
      fails++;
      $display("FAIL first_step: got ptr=%0d, expected 1", ptr);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex !== 48'hFDFF_8986_C7C7) begin
      fails++;
      $display("FAIL ptr1_window: got hex=%h, expected fdff8986c7c7", hex);
    end
    n = 0;
    while (ptr !== 4'd3 && n < 50) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex !== 48'h8986_C7C7_C0FF) begin
      fails++;
      $display("FAIL ptr3_window: got hex=%h, expected 8986c7c7c0ff (waited %0d cycles)", hex, n);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    while (ptr !== 4'd15 && n < 100) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (hex !== 48'hFDFD_FDFF_8986) begin
      fails++;
      $display("FAIL ptr15_window: got hex=%h, expected fdfdfdff8986", hex);
    end
    n = 0;
    while (ptr !== 4'd0 && n < 2 * STEP) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (ptr !== 4'd0) begin
      fails++;
      $display("FAIL wrap: got ptr=%0d, expected 0", ptr);
    end
  endtask

  task automatic test_hold();
    logic [3:0]  held_ptr;
    logic [47:0] held_hex;
    int          need, n;
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    held_ptr = m_ptr;
    held_hex = window_of(m_ptr);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (ptr !== held_ptr || hex !== held_hex) begin
        fails++;
        $display("FAIL hold: got ptr=%0d hex=%h, expected ptr=%0d hex=%h",
                 ptr, hex, held_ptr, held_hex);
      end
    end
    need = STEP - m_cnt;
    n = 0;
    while (n < 2 * STEP) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
      if (ptr !== held_ptr) break;
    end
    checks++;
    if (n !== need || ptr !== held_ptr + 4'd1) begin
      fails++;
      $display("FAIL hold_resume: got %0d cycles to ptr=%0d, expected %0d cycles to ptr=%0d",
               n, ptr, need, held_ptr + 4'd1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!(m_ptr == 4'd7 && m_cnt == 2) && n < 200) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (ptr !== 4'd7) begin
      fails++;
      $display("FAIL reach_ptr7: got ptr=%0d, expected 7", ptr);
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (ptr !== 4'd0 || hex !== 48'hFFFF_FFFF_FFFF) begin
      fails++;
      $display("FAIL reset_mid: got ptr=%0d hex=%h, expected ptr=0 hex=ffffffffffff", ptr, hex);
    end
    for (int i = 1; i <= STEP; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (ptr !== ((i == STEP) ? 4'd1 : 4'd0)) begin
        fails++;
        $display("FAIL reset_no_carry: cycle %0d got ptr=%0d, expected %0d",
                 i, ptr, (i == STEP) ? 1 : 0);
      end
    end
  endtask

`ifdef MESSAGE_PAUSE_EN
  task automatic test_pause();
    logic [3:0] held_ptr;
    int         need, n;
    drive_cycle(1'b0, 1'b1, 1'b0);
    held_ptr = m_ptr;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1);
      checks++;
      if (ptr !== held_ptr) begin
        fails++;
        $display("FAIL pause: got ptr=%0d, expected %0d", ptr, held_ptr);
      end
    end
    need = STEP - m_cnt;
    n = 0;
    while (n < 2 * STEP) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n++;
      if (ptr !== held_ptr) break;
    end
    checks++;
    if (n !== need) begin
      fails++;
      $display("FAIL pause_resume: got %0d cycles, expected %0d", n, need);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_wrap();
    test_hold();
    test_reset_mid();
`ifdef MESSAGE_PAUSE_EN
    test_pause();
`endif
    test_random();
    // let the monitor drain the final expectation
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
